// File: rtl/train_ctrl_pkg.sv
// Shared train-controller definitions: field widths, state codes and timing constants.
package train_ctrl_pkg;

   localparam int STATE_W  = 4;
   localparam int TIME_W   = 19;
   localparam int MS_PER_S = 1000;

   localparam logic [STATE_W-1:0] S_START = 4'b0000;
   localparam logic [STATE_W-1:0] S_WAIT  = 4'b0011;
   localparam logic [STATE_W-1:0] S_STOP  = 4'b0100;

   // Prescaler width: enough bits for 0..div-1, never narrower than one bit.
   function automatic int calc_cnt_w(input int div);
      int w;
      w = $clog2(div);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts enabled cycles 0..TICK_DIV-1 and flags the wrap cycle.
module ms_tick_gen
   import train_ctrl_pkg::*;
#(
   parameter int TICK_DIV = 50_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = calc_cnt_w(TICK_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;

   // Tick is the last enabled cycle of a millisecond; a clear wins over it.
   assign tick = en & ~clr & (r_cnt == LAST);

   // Prescaler counter: cleared on reset or load, frozen while disabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= ZERO;
      end else if (clr) begin
         r_cnt <= ZERO;
      end else if (en) begin
         if (r_cnt == LAST) begin
            r_cnt <= ZERO;
         end else begin
            r_cnt <= r_cnt + ONE;
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/state_timer.sv
// Per-state dwell timer: reloads on every state change and counts down in ms.
// Define STATE_TIMER_FAST_SIM_EN to decrement once per enabled cycle (TICK_DIV = 1).
module state_timer
   import train_ctrl_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STATE_W-1:0] present_state,
   input  logic [TIME_W-1:0]  t,
   input  logic               hold,
   output logic               timeout,
   output logic               expired,
   output logic               busy,
   output logic [TIME_W-1:0]  remaining
);

`ifdef STATE_TIMER_FAST_SIM_EN
   localparam int TICK_DIV = 1;
`else
   localparam int TICK_DIV = CLK_HZ / MS_PER_S;
`endif

   localparam logic [TIME_W-1:0] T_ZERO = {TIME_W{1'b0}};
   localparam logic [TIME_W-1:0] T_ONE  = TIME_W'(1);

   logic [STATE_W-1:0] r_prev_state;
   logic               r_load_p;
   logic [TIME_W-1:0]  r_remaining;
   logic               r_busy;
   logic               r_timeout;
   logic               r_expired;

   logic               w_change;
   logic               w_en;
   logic               w_tick;
   logic [TIME_W-1:0]  w_rem_next;
   logic               w_timeout_next;
   logic               w_expired_next;

   assign w_change = (present_state != r_prev_state);
   assign w_en     = r_busy & ~hold;

   ms_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_ms_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (w_en),
      .clr  (r_load_p),
      .tick (w_tick)
   );

   // Next countdown state; a load overrides a decrement landing in the same cycle.
   always_comb begin
      w_rem_next     = r_remaining;
      w_timeout_next = 1'b0;
      w_expired_next = r_expired;
      if (r_load_p) begin
         w_rem_next     = t;
         w_expired_next = 1'b0;
      end else if (w_tick && (r_remaining != T_ZERO)) begin
         w_rem_next = r_remaining - T_ONE;
         if (r_remaining == T_ONE) begin
            w_timeout_next = 1'b1;
            w_expired_next = 1'b1;
         end else begin
            w_expired_next = r_expired;
         end
      end else begin
         w_rem_next = r_remaining;
      end
   end

   // State tracking and registered outputs; reset arms a load for the first cycle out.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_state <= {STATE_W{1'b0}};
         r_load_p     <= 1'b1;
         r_remaining  <= T_ZERO;
         r_busy       <= 1'b0;
         r_timeout    <= 1'b0;
         r_expired    <= 1'b0;
      end else begin
         r_prev_state <= present_state;
         r_load_p     <= w_change;
         r_remaining  <= w_rem_next;
         r_busy       <= (w_rem_next != T_ZERO);
         r_timeout    <= w_timeout_next;
         r_expired    <= w_expired_next;
      end
   end

   assign timeout   = r_timeout;
   assign expired   = r_expired;
   assign busy      = r_busy;
   assign remaining = r_remaining;

endmodule

// File: tb/tb_state_timer.sv
// Self-checking bench for state_timer: directed scenarios plus random traffic against a dwell model.
module tb_state_timer;

   localparam int CLK_HZ_TB = 10_000;
`ifdef STATE_TIMER_FAST_SIM_EN
   localparam int D = 1;
`else
   localparam int D = CLK_HZ_TB / 1000;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  present_state;
   logic [18:0] t;
   logic        hold;
   logic        timeout;
   logic        expired;
   logic        busy;
   logic [18:0] remaining;

   state_timer #(
      .CLK_HZ (CLK_HZ_TB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .present_state (present_state),
      .t             (t),
      .hold          (hold),
      .timeout       (timeout),
      .expired       (expired),
      .busy          (busy),
      .remaining     (remaining)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cycn        = 0;
   int load_cyc    = 0;
   int seen_to     = 0;
   int seen_exp    = 0;

   // Reference model: dwell length N and enabled cycles worked since load.
   logic [3:0] m_prev    = 4'd0;
   bit         m_pend    = 1'b0;
   int         m_n       = 0;
   int         m_work    = 0;
   bit         m_to      = 1'b0;
   bit         m_exp     = 1'b0;

   function automatic int m_rem();
      return m_n - (m_work / D);
   endfunction

   task automatic model_step();
      bit load;
      if (rst) begin
         m_prev = 4'd0; m_pend = 1'b1; m_n = 0; m_work = 0; m_to = 1'b0; m_exp = 1'b0;
      end else begin
         load   = m_pend;
         m_pend = (present_state != m_prev);
         m_prev = present_state;
         m_to   = 1'b0;
         if (load) begin
            m_n = int'(t); m_work = 0; m_exp = 1'b0;
         end else if (m_rem() > 0 && !hold) begin
            m_work++;
            if (m_work == m_n * D) begin
               m_to = 1'b1; m_exp = 1'b1;
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycn);
      end
   endtask

   task automatic cyc();
      logic [21:0] exp_v;
      @(posedge clk);
      model_step();
      @(negedge clk);
      cycn++;
      if (timeout === 1'b1) seen_to++;
      if (expired === 1'b1) seen_exp++;
      exp_v = {m_to, m_exp, (m_rem() != 0), 19'(m_rem())};
      check("outputs{to,exp,busy,rem}", {10'd0, timeout, expired, busy, remaining}, {10'd0, exp_v});
   endtask

   task automatic set_state_t(input logic [3:0] s, input logic [18:0] tv);
      present_state = s;
      cyc();
      t = tv;
      cyc();
      load_cyc = cycn;
   endtask

   task automatic wait_to(input int maxc, output int n);
      n = -1;
      for (int i = 0; i < maxc; i++) begin
         cyc();
         if (timeout === 1'b1) begin
            n = cycn - load_cyc;
            break;
         end
      end
   endtask

   task automatic wait_rem(input int val, input int maxc, output bit found);
      found = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         cyc();
         if (remaining === 19'(val)) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int  n;
      bit  found;
      int  r;

      // Reset with state S_START and a 2000 ms dwell waiting on t.
      rst = 1'b1; hold = 1'b0; present_state = 4'b0000; t = 19'd2000;
      repeat (3) cyc();
      check("reset_outputs", {28'd0, timeout, expired, busy, |remaining}, 32'd0);
      rst = 1'b0;
      cyc();
      load_cyc = cycn;
      check("first_load_rem", 32'(remaining), 32'd2000);
      wait_to(2000 * D + 5, n);
      check("t2000_latency", n, 2000 * D);
      repeat (10) cyc();
      check("t2000_hold_exp", {30'd0, expired, busy}, 32'b10);

      // Hold for 100 cycles in the middle of a 1000 ms wait.
      set_state_t(4'b0011, 19'd1000);
      wait_rem(500, 1000 * D, found);
      check("reach_rem500", 32'(found), 32'd1);
      hold = 1'b1;
      seen_to = 0;
      repeat (100) cyc();
      check("no_to_in_hold", seen_to, 0);
      check("rem_frozen", 32'(remaining), 32'd500);
      hold = 1'b0;
      wait_to(1000 * D + 5, n);
      check("hold_latency", n, 1000 * D + 100);

      // Abort a running dwell at remaining=5.
      set_state_t(4'b0001, 19'd20);
      wait_rem(5, 20 * D, found);
      check("reach_rem5", 32'(found), 32'd1);
      seen_to = 0;
      set_state_t(4'b0100, 19'd2000);
      check("abort_rem", 32'(remaining), 32'd2000);
      check("abort_flags", {30'd0, timeout, expired}, 32'd0);
      check("abort_no_to", seen_to, 0);

      // Zero-length dwell.
      set_state_t(4'b0001, 19'd0);
      seen_to = 0; seen_exp = 0;
      repeat (50) cyc();
      check("t0_busy", 32'(busy), 32'd0);
      check("t0_no_pulse", seen_to + seen_exp, 0);

      // Exact-latency 3 ms dwell.
      set_state_t(4'b0010, 19'd3);
      wait_to(3 * D + 5, n);
      check("t3_latency", n, 3 * D);

      // Load coinciding with the expiry cycle.
      set_state_t(4'b0101, 19'd3);
      seen_to = 0;
      while (cycn < load_cyc + 3 * D - 2) cyc();
      set_state_t(4'b0110, 19'd7);
      check("collide_rem", 32'(remaining), 32'd7);
      check("collide_no_to", seen_to, 0);

      // Reset in the middle of a count.
      set_state_t(4'b0111, 19'd3);
      seen_to = 0;
      repeat ((3 * D) / 2) cyc();
      rst = 1'b1;
      cyc();
      check("midrst_outputs", {28'd0, timeout, expired, busy, |remaining}, 32'd0);
      cyc();
      check("midrst_no_to", seen_to, 0);
      rst = 1'b0;
      repeat (5) cyc();

      // Random traffic checked cycle-by-cycle against the model.
      for (int k = 0; k < 400; k++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3: begin
               present_state = 4'($urandom_range(0, 15));
               cyc();
               t = 19'($urandom_range(0, 12));
            end
            4, 5: hold = 1'($urandom_range(0, 1));
            6: begin
               rst = 1'b1;
               repeat ($urandom_range(1, 2)) cyc();
               rst = 1'b0;
            end
            default: ;
         endcase
         repeat ($urandom_range(1, 3 * D + 2)) cyc();
      end
      hold = 1'b0;
      repeat (200) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/state_timer.md
STATE_TIMER -- requirements
Module: state_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning the clk frequency in Hz; the block SHALL derive TICK_DIV = CLK_HZ/1000 clocks per ms from it.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic acts on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port present_state, input, 4 bits: the controller state code, the same value the upstream parameter stage receives.
REQ-005 SHALL have port t, input, 19 bits: the dwell time in ms from the parameter stage, registered there, so it lags present_state by 1 cycle.
REQ-006 SHALL have port hold, input, 1 bit: while 1, the countdown freezes.
REQ-007 SHALL have port timeout, output, 1 bit: a 1-cycle pulse on expiry.
REQ-008 SHALL have port expired, output, 1 bit: a level, held from expiry until the next load.
REQ-009 SHALL have port busy, output, 1 bit: 1 while remaining != 0.
REQ-010 SHALL have port remaining, output, 19 bits: the ms left in the current dwell.

Function
REQ-011 SHALL register prev_state; change = (present_state != prev_state).
REQ-012 SHALL register load_p <= change, so a load occurs 1 cycle after the change and aligns with the lagged t.
REQ-013 SHALL act on every cycle where load_p=1 (the load cycle): remaining <= t, prescaler <= 0, expired <= 0, timeout <= 0.
REQ-014 SHALL count the prescaler 0..TICK_DIV-1 only while busy=1 and hold=0; at TICK_DIV-1 it wraps to 0 and remaining decrements by 1.
REQ-015 SHALL time expiry as follows: with t=N>0 and hold never asserted, remaining SHALL reach 0 exactly N*TICK_DIV cycles after the load edge, and timeout=1 and expired=1 in that same cycle.
REQ-016 SHALL keep timeout high for exactly 1 cycle; expired SHALL stay 1 until the next load or rst.
REQ-017 SHALL treat t=0 at load as a no-op dwell: busy=0, and no timeout or expired is ever produced for that state.
REQ-018 SHALL, when a state change occurs while busy, abort the running count and restart with the new t at the next load; no timeout SHALL be emitted for the aborted dwell.
REQ-019 SHALL give a load precedence over the decrement when both fall in the same cycle as expiry: no timeout pulse, and remaining = new t.
REQ-020 SHALL let hold=1 freeze both the prescaler and remaining; timeout SHALL NOT fire while hold=1; the count resumes from the frozen prescaler value.
REQ-021 SHALL never decrement remaining below 0 or wrap it.
REQ-022 SHALL drive all outputs from registers; there is no combinational path from input to output.

Reset
REQ-023 SHALL, while rst=1: timeout=0, expired=0, busy=0, remaining=0, prescaler=0, prev_state=4'b0000.
REQ-024 SHALL set load_p <= 1 during rst, so the first cycle after reset loads t for the state present at the reset edge.
REQ-025 SHALL let rst asserted mid-count abandon the count with no timeout pulse.

Configuration
REQ-026 SHALL provide macro STATE_TIMER_FAST_SIM_EN.
- Defined: TICK_DIV is forced to 1; remaining decrements every enabled cycle.
- Undefined: TICK_DIV = CLK_HZ/1000.
- The prescaler width SHALL be max(1, clog2(TICK_DIV)).

Structure
REQ-027 SHALL place in shared package train_ctrl_pkg:
- STATE_W=4 and TIME_W=19.
- State code constants S_START=4'b0000, S_WAIT=4'b0011, S_STOP=4'b0100.
- The ms-per-second constant 1000.
REQ-028 SHALL implement the prescaler as sub-module ms_tick_gen, with inputs clk, rst, en, clr and output tick.

Verification
REQ-029 SHALL cover, with FAST_SIM defined: release rst with state=0000 and t=2000 -> timeout pulse 2000 cycles after the load edge, then expired=1 and busy=0 held.
REQ-030 SHALL cover, with FAST_SIM: state 0011, t=1000, hold=1 for 100 cycles starting at remaining=500 -> timeout 1100 cycles after load.
REQ-031 SHALL cover, with FAST_SIM: at remaining=5, change to 0100 with t=2000 -> no timeout, remaining=2000 one cycle after the change, expired=0.
REQ-032 SHALL cover, with FAST_SIM: state 0001 with t=0 -> busy=0, timeout and expired stay 0 for 50 cycles.
REQ-033 SHALL cover, with FAST_SIM: state change timed so load_p=1 in the cycle remaining would hit 0 -> no timeout pulse, and remaining = new t.
REQ-034 SHALL cover, without FAST_SIM, CLK_HZ=10_000: t=3 -> timeout exactly 30 cycles after load; rst at cycle 15 -> no pulse, all outputs 0.
